// File: rtl/layer1_pkg.sv
// Shared definitions for the layer-1 MAC column sequencer.
// Holds default geometry, address widths, FSM state encodings and the
// tap tag that travels alongside each issued address.
package layer1_pkg;

  localparam int unsigned N_TAPS_DEF    = 9;
  localparam int unsigned N_GROUPS_DEF  = 10;
  localparam int unsigned ALIGN_LAT_DEF = 2;
  localparam int unsigned WA_W_DEF      = 8;
  localparam int unsigned PA_W_DEF      = 4;
  localparam int unsigned GROUP_W       = 4;

  // FSM state encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  typedef struct packed {
    logic               valid;
    logic               first;
    logic               last;
    logic [GROUP_W-1:0] group;
  } tag_t;

endpackage

// File: rtl/layer1_tag_delay.sv
// DEPTH-stage shift register carrying tap tags from address issue to the
// cycle the datapath consumes that tap. Reset clears every stage, so an
// emptied pipeline reads back as "no valid tap".
// Ports:
//   clk     - clock
//   reset   - asynchronous active-high reset
//   tag_in  - tag of the address issued this cycle
//   tag_out - tag issued DEPTH cycles ago
module layer1_tag_delay
  import layer1_pkg::*;
#(
  parameter int unsigned DEPTH = ALIGN_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/layer1_sequencer.sv
// Sequencer for the 10-lane layer-1 MAC column datapath. Each start runs
// N_GROUPS back-to-back groups of N_TAPS taps, issuing weight/pixel
// addresses, driving the accumulator clear aligned to memory latency and
// flagging the cycle in which the column holds a finished group sum.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - begin a run (only honoured when idle)
//   busy        - run in progress (through the done cycle)
//   addr_valid  - w_addr/p_addr valid this cycle
//   w_addr      - weight address g*N_TAPS + t
//   p_addr      - pixel address t
//   acc_clr     - 1 forces the datapath accumulator input to 0
//   col_valid   - column holds the finished sum of group col_group
//   col_group   - group index qualified by col_valid
//   done        - pulse with the final col_valid of a run
module layer1_sequencer
  import layer1_pkg::*;
#(
  parameter int unsigned N_TAPS    = N_TAPS_DEF,
  parameter int unsigned N_GROUPS  = N_GROUPS_DEF,
  parameter int unsigned ALIGN_LAT = ALIGN_LAT_DEF,
  parameter int unsigned WA_W      = WA_W_DEF,
  parameter int unsigned PA_W      = PA_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            addr_valid,
  output logic [WA_W-1:0] w_addr,
  output logic [PA_W-1:0] p_addr,
  output logic            acc_clr,
  output logic            col_valid,
  output logic [3:0]      col_group,
  output logic            done
);

  localparam int unsigned TW = $clog2(N_TAPS);
  localparam int unsigned GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int unsigned DW = $clog2(ALIGN_LAT + 1);

  logic [1:0]      state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [GW-1:0]   g_q, g_d;
  logic [WA_W-1:0] w_q, w_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            col_valid_q;
  logic [3:0]      col_group_q;
  logic            done_q;

  tag_t tag_in, tag_out;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    g_d     = g_q;
    w_d     = w_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          t_d     = '0;
          g_d     = '0;
          w_d     = '0;
        end
      end
      StIssue: begin
        w_d = w_q + WA_W'(1);
        if (t_q == TW'(N_TAPS - 1)) begin
          t_d = '0;
          if (g_q == GW'(N_GROUPS - 1)) begin
            // Last tap of the run: park counters at zero while draining.
            g_d     = '0;
            w_d     = '0;
            drain_d = '0;
            state_d = StDrain;
          end else begin
            g_d = g_q + GW'(1);
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StDrain: begin
        // ALIGN_LAT+1 cycles: tags flush out, then the final col_valid/done.
        if (drain_q == DW'(ALIGN_LAT)) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_in.valid = (state_q == StIssue);
    tag_in.first = (t_q == '0);
    tag_in.last  = (t_q == TW'(N_TAPS - 1));
    tag_in.group = GROUP_W'(g_q);
  end

  layer1_tag_delay #(
    .DEPTH(ALIGN_LAT)
  ) u_tag_delay (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      t_q         <= '0;
      g_q         <= '0;
      w_q         <= '0;
      drain_q     <= '0;
      col_valid_q <= 1'b0;
      col_group_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      g_q         <= g_d;
      w_q         <= w_d;
      drain_q     <= drain_d;
      // The sum is complete one cycle after the last tap reaches the datapath.
      col_valid_q <= tag_out.valid & tag_out.last;
      if (tag_out.valid & tag_out.last) begin
        col_group_q <= tag_out.group;
      end
      done_q      <= tag_out.valid & tag_out.last &
                     (tag_out.group == GROUP_W'(N_GROUPS - 1));
    end
  end

  assign busy       = (state_q != StIdle);
  assign addr_valid = (state_q == StIssue);
  assign w_addr     = w_q;
  assign p_addr     = PA_W'(t_q);
  // No valid tap in flight keeps the accumulator cleared.
  assign acc_clr    = ~tag_out.valid | tag_out.first;
  assign col_valid  = col_valid_q;
  assign col_group  = col_group_q;
  assign done       = done_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
module tb_layer1_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: N_TAPS=4, N_GROUPS=2, ALIGN_LAT=2
  logic busy, addr_valid, acc_clr, col_valid, done;
  logic [7:0] w_addr;
  logic [3:0] p_addr, col_group;
  layer1_sequencer #(.N_TAPS(4), .N_GROUPS(2), .ALIGN_LAT(2), .WA_W(8), .PA_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .addr_valid(addr_valid),
    .w_addr(w_addr), .p_addr(p_addr), .acc_clr(acc_clr), .col_valid(col_valid),
    .col_group(col_group), .done(done)
  );

  // Variant ALIGN_LAT=1
  logic busy_a1, av_a1, clr_a1, cv_a1, dn_a1;
  logic [7:0] w_a1;
  logic [3:0] p_a1, cg_a1;
  layer1_sequencer #(.N_TAPS(4), .N_GROUPS(2), .ALIGN_LAT(1), .WA_W(8), .PA_W(4)) dut_a1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a1), .addr_valid(av_a1),
    .w_addr(w_a1), .p_addr(p_a1), .acc_clr(clr_a1), .col_valid(cv_a1),
    .col_group(cg_a1), .done(dn_a1)
  );

  // Variant ALIGN_LAT=4
  logic busy_a4, av_a4, clr_a4, cv_a4, dn_a4;
  logic [7:0] w_a4;
  logic [3:0] p_a4, cg_a4;
  layer1_sequencer #(.N_TAPS(4), .N_GROUPS(2), .ALIGN_LAT(4), .WA_W(8), .PA_W(4)) dut_a4 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a4), .addr_valid(av_a4),
    .w_addr(w_a4), .p_addr(p_a4), .acc_clr(clr_a4), .col_valid(cv_a4),
    .col_group(cg_a4), .done(dn_a4)
  );

  // Variant N_TAPS=2, N_GROUPS=1
  logic busy_s, av_s, clr_s, cv_s, dn_s;
  logic [7:0] w_s;
  logic [3:0] p_s, cg_s;
  layer1_sequencer #(.N_TAPS(2), .N_GROUPS(1), .ALIGN_LAT(2), .WA_W(8), .PA_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .busy(busy_s), .addr_valid(av_s),
    .w_addr(w_s), .p_addr(p_s), .acc_clr(clr_s), .col_valid(cv_s),
    .col_group(cg_s), .done(dn_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected col_valid events on the main instance.
  typedef struct {
    int         at;
    logic [3:0] grp;
    logic       dn;
  } sb_t;
  sb_t sb[$];

  task automatic push_run(input int c0);
    for (int g = 0; g < 2; g++) begin
      sb_t e;
      e.at  = c0 + 4 * (g + 1) + 2 + 1;
      e.grp = 4'(g);
      e.dn  = (g == 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (done && !col_valid) chk("done_without_col_valid", 32'(done), 32'd0);
    if (col_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_col_valid", 32'(col_valid), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_col_cycle", cyc, e.at);
        chk("sb_col_group", 32'(col_group), 32'(e.grp));
        chk("sb_done", 32'(done), 32'(e.dn));
      end
    end
  end

  // Main-scenario vectors: row k is cycle k relative to the start-sampling cycle.
  typedef struct {
    logic       start;
    logic       av;
    logic [7:0] w;
    logic [3:0] p;
    logic       clr;
    logic       cv;
    logic [3:0] cg;
    logic       dn;
    logic       bsy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic s, input logic av, input int w, input int p, input logic clr,
                     input logic cv, input int cg, input logic dn, input logic bsy);
    vec_t v;
    v.start = s; v.av = av; v.w = 8'(w); v.p = 4'(p); v.clr = clr;
    v.cv = cv; v.cg = 4'(cg); v.dn = dn; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  // Closed-form timeline of a run sampled at start cycle 0.
  typedef struct packed {
    logic       av;
    logic [7:0] w;
    logic       clr;
    logic       cv;
    logic [3:0] cg;
    logic       dn;
    logic       bsy;
  } exp_t;

  function automatic exp_t expect_at(input int t, input int g, input int l, input int k);
    exp_t e;
    int j;
    e = '0;
    if (k >= 1 && k <= t * g) begin
      e.av = 1'b1;
      e.w  = 8'(k - 1);
    end
    j = k - l;
    e.clr = !(j >= 1 && j <= t * g && ((j - 1) % t) != 0);
    j = k - l - 1;
    if (j >= 1 && j <= t * g && ((j - 1) % t) == t - 1) begin
      e.cv = 1'b1;
      e.cg = 4'((j - 1) / t);
      e.dn = (((j - 1) / t) == g - 1);
    end
    e.bsy = (k >= 1 && k <= t * g + l + 1);
    return e;
  endfunction

  task automatic chk_var(input string nm, input exp_t e, input logic av, input logic [7:0] w,
                         input logic clr, input logic cv, input logic [3:0] cg,
                         input logic dn, input logic bsy);
    chk({nm, "_addr_valid"}, 32'(av), 32'(e.av));
    if (e.av) chk({nm, "_w_addr"}, 32'(w), 32'(e.w));
    chk({nm, "_acc_clr"}, 32'(clr), 32'(e.clr));
    chk({nm, "_col_valid"}, 32'(cv), 32'(e.cv));
    if (e.cv) chk({nm, "_col_group"}, 32'(cg), 32'(e.cg));
    chk({nm, "_done"}, 32'(dn), 32'(e.dn));
    chk({nm, "_busy"}, 32'(bsy), 32'(e.bsy));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_addr_valid"}, 32'(addr_valid), 32'd0);
    chk({nm, "_w_addr"}, 32'(w_addr), 32'd0);
    chk({nm, "_p_addr"}, 32'(p_addr), 32'd0);
    chk({nm, "_acc_clr"}, 32'(acc_clr), 32'd1);
    chk({nm, "_col_valid"}, 32'(col_valid), 32'd0);
    chk({nm, "_col_group"}, 32'(col_group), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && !busy_a1 && !busy_a4 && !busy_s) break;
    end
    chk("idle_within_bound", 32'(i < bound), 32'd1);
  endtask

  initial begin
    int c0;
    exp_t e;

    //      start av  w  p clr cv cg dn busy
    add(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 2, 2, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 3, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1); // start while busy
    add(1'b0, 1'b1, 5, 1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 6, 2, 1'b1, 1'b1, 0, 1'b0, 1'b1); // g0 sum, g1 tap0 clear
    add(1'b0, 1'b1, 7, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b1); // start in done cycle
    add(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven main scenario
    c0 = cyc;
    push_run(c0);
    for (int k = 0; k < tbl.size(); k++) begin
      start = tbl[k].start;
      chk("tbl_addr_valid", 32'(addr_valid), 32'(tbl[k].av));
      if (tbl[k].av) begin
        chk("tbl_w_addr", 32'(w_addr), 32'(tbl[k].w));
        chk("tbl_p_addr", 32'(p_addr), 32'(tbl[k].p));
      end
      chk("tbl_acc_clr", 32'(acc_clr), 32'(tbl[k].clr));
      chk("tbl_col_valid", 32'(col_valid), 32'(tbl[k].cv));
      if (tbl[k].cv) chk("tbl_col_group", 32'(col_group), 32'(tbl[k].cg));
      chk("tbl_done", 32'(done), 32'(tbl[k].dn));
      chk("tbl_busy", 32'(busy), 32'(tbl[k].bsy));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle(40);

    // start held high: second run begins the cycle after the idle cycle
    start = 1'b1;
    c0 = cyc;
    push_run(c0);
    push_run(c0 + 12);
    for (int k = 0; k <= 13; k++) begin
      if (k == 13) start = 1'b0;
      if (k >= 1 && k <= 8) chk("held_addr_valid_run1", 32'(addr_valid), 32'd1);
      if (k == 11) chk("held_done", 32'(done), 32'd1);
      if (k == 12) begin
        chk("held_idle_busy", 32'(busy), 32'd0);
        chk("held_idle_addr_valid", 32'(addr_valid), 32'd0);
      end
      if (k == 13) begin
        chk("held_run2_addr_valid", 32'(addr_valid), 32'd1);
        chk("held_run2_w_addr", 32'(w_addr), 32'd0);
      end
      @(negedge clk);
    end
    wait_idle(40);
    chk("held_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("held_no_third_run", 32'(addr_valid | busy), 32'd0);

    // Asynchronous reset mid-run
    start = 1'b1;
    c0 = cyc;
    push_run(c0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_addr_valid", 32'(addr_valid), 32'd0);
    start = 1'b1;
    c0 = cyc;
    push_run(c0);
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    // Latency and geometry variants, all driven by one start pulse
    start = 1'b1;
    c0 = cyc;
    push_run(c0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      e = expect_at(4, 2, 1, k);
      chk_var("lat1", e, av_a1, w_a1, clr_a1, cv_a1, cg_a1, dn_a1, busy_a1);
      e = expect_at(4, 2, 4, k);
      chk_var("lat4", e, av_a4, w_a4, clr_a4, cv_a4, cg_a4, dn_a4, busy_a4);
      e = expect_at(2, 1, 2, k);
      chk_var("small", e, av_s, w_s, clr_s, cv_s, cg_s, dn_s, busy_s);
      if (av_s) chk("small_p_addr", 32'(p_s), 32'((k - 1) % 2));
      @(negedge clk);
    end
    wait_idle(40);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/layer1_sequencer.md
Name: layer1_sequencer

Overview:
- Controller that sequences the 10-lane layer-1 MAC column datapath: broadcast 9-bit weight, 160-bit pixel bus, accumulator-clear input.
- Per start command it runs N_GROUPS back-to-back accumulation passes of N_TAPS taps each.
- Issues weight/pixel memory addresses and drives the datapath accumulator clear, aligned to memory and datapath latency.
- Flags the cycle in which the column output holds a finished sum.

Parameters:
N_TAPS, 9, taps accumulated per group (>=2)
N_GROUPS, 10, groups per run (>=1)
ALIGN_LAT, 2, cycles from address issue to the cycle the datapath must see that tap's clear/accumulate control (memory read + weight register), >=1
WA_W, 8, weight address width (must hold N_GROUPS*N_TAPS-1)
PA_W, 4, pixel address width (must hold N_TAPS-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin a run; sampled only in IDLE
busy  out  1  run in progress
addr_valid  out  1  w_addr/p_addr valid this cycle
w_addr  out  WA_W  weight address = g*N_TAPS + t
p_addr  out  PA_W  pixel address = t
acc_clr  out  1  drives datapath reset: 1 = accumulator input forced to 0
col_valid  out  1  column bus holds the finished sum of group col_group this cycle
col_group  out  4  group index of the sum flagged by col_valid
done  out  1  one-cycle pulse, coincides with the final col_valid

Behaviour:
- Reset values:
  - busy=0, addr_valid=0, w_addr=0, p_addr=0, acc_clr=1, col_valid=0, col_group=0, done=0.
  - Delay pipeline and all counters cleared.
- States:
  - IDLE: start=1 at an edge -> ISSUE. Tap counter t=0, group counter g=0.
  - ISSUE: addr_valid=1 every cycle, t increments. At t=N_TAPS-1, t wraps to 0 and g increments. After tap (N_GROUPS-1, N_TAPS-1) -> DRAIN.
  - DRAIN: addr_valid=0. Waits for the delay pipeline to empty (ALIGN_LAT+1 cycles), then -> IDLE.
- No idle cycles between groups or between taps.
- busy=1 from the first ISSUE cycle through the done cycle inclusive.
- Tag pipeline:
  - Each issued address carries a tag {first=(t==0), last=(t==N_TAPS-1), g}.
  - Tags go through an ALIGN_LAT-deep shift register.
- At the aligned cycle:
  - acc_clr=1 if the tag is first, 0 if it is a valid non-first tap.
  - acc_clr=1 whenever no valid tag is present (idle/drain): the datapath stays cleared.
- One cycle after the aligned cycle of a last tag:
  - col_valid=1 and col_group=g for one cycle.
  - done=1 additionally if g=N_GROUPS-1.
- Back-to-back groups: col_valid for group g lands in the same cycle as acc_clr for tap 0 of group g+1. The column still holds g's sum that cycle and is overwritten at the next edge. Downstream must capture on col_valid; there is no backpressure.
- start while busy: ignored. start in the done cycle: ignored. start in the cycle after done: accepted.
- reset mid-run: immediate abort. Outputs return to reset values and no done is produced.
- Width rules:
  - Counters sized by $clog2.
  - w_addr computed by an incrementing register, not a multiplier.
  - w_addr runs 0..N_GROUPS*N_TAPS-1 continuously across groups.

Decomposition:
- Shared package layer1_pkg:
  - Default N_TAPS, N_GROUPS, ALIGN_LAT.
  - Address widths.
  - State encoding constants (IDLE, ISSUE, DRAIN).
  - Tag struct {valid, first, last, group}.
- One sub-module, natural to split out: layer1_tag_delay, a parameterised DEPTH-stage valid/tag shift register, reset-cleared.
- FSM and counters stay in the top module.

Test Plan:
- N_TAPS=4, N_GROUPS=2, ALIGN_LAT=2; start sampled high at edge of cycle 0 -> addr_valid cycles 1-8, w_addr 0..7, p_addr 0,1,2,3,0,1,2,3; acc_clr=0 cycles 4-6 and 8-10, 1 elsewhere; col_valid cycle 7 (col_group 0) and cycle 11 (col_group 1); done cycle 11 only; busy cycles 1-11.
- Pair with the real datapath, all weights=1, lane k pixels=k+1 every tap, N_TAPS=9 -> at each col_valid lane k reads 9*(k+1), no carry-over between groups.
- start held high continuously -> second run's first addr_valid in cycle 13, exactly one cycle after done in cycle 11 (cycle 12 sampled IDLE); no start pulses lost or double-counted mid-run.
- reset asserted asynchronously in cycle 5 of the first scenario -> outputs at reset values within the same cycle; no col_valid/done afterwards; a subsequent start runs a full clean sequence.
- ALIGN_LAT=1 and ALIGN_LAT=4 variants of the first scenario -> acc_clr and col_valid shift by -1/+2 cycles; addresses unchanged.
- N_GROUPS=1, N_TAPS=2 -> addr_valid cycles 1-2, acc_clr=0 at cycle 4 only, col_valid=done at cycle 5.
